// File: rtl/pkt_classifier_pkg.sv
// rtl/pkt_classifier_pkg.sv - shared widths, ctrl codes and FSM encoding for the classifier
package pkt_classifier_pkg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int FIFO_W = 72;

  localparam logic [CTRL_W-1:0] CTRL_HDR  = 8'hFF;
  localparam logic [CTRL_W-1:0] CTRL_DATA = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pkt_classifier.sv
// rtl/pkt_classifier.sv - packet delineation, drop decision and stats ahead of drop_fifo
module pkt_classifier
  import pkt_classifier_pkg::*;
#(
  parameter int MATCH_WORD = 2,
  parameter int MAX_WORDS  = 200,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_wr,
  output logic              in_rdy,
  input  logic              fifo_nearly_full,
  input  logic              match_en,
  input  logic [DATA_W-1:0] match_value,
  input  logic [DATA_W-1:0] match_mask,
  output logic [FIFO_W-1:0] out_fifo_data,
  output logic              fifowrite,
  output logic              firstword,
  output logic              lastword,
  output logic              drop_pkt,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [7:0] MATCH_IDX = 8'(MATCH_WORD);
  localparam logic [8:0] MAX_W9    = 9'(MAX_WORDS);

  state_t     state;
  logic [7:0] word_cnt;
  logic       drop_flag;

  logic       accepted, is_hdr, is_data;
  logic       first, write, last;
  logic [7:0] idx, next_cnt;
  logic       match_hit, over, set_cond, drop_now;

  assign in_rdy   = !rst && !fifo_nearly_full;
  assign accepted = in_wr && in_rdy;
  assign is_hdr   = (in_ctrl == CTRL_HDR);
  assign is_data  = (in_ctrl == CTRL_DATA);

  // Non-header words arriving in IDLE belong to no packet and are dropped silently.
  assign first = accepted && (state == ST_IDLE) && is_hdr;
  assign write = first || (accepted && (state != ST_IDLE));
  assign last  = accepted &&
                 (((state == ST_HDR) && !is_hdr && !is_data) ||
                  ((state == ST_PAYLOAD) && !is_data));

  // word_cnt holds the number of words already taken, i.e. the index of the current word.
  assign idx       = (state == ST_IDLE) ? 8'd0 : word_cnt;
  assign next_cnt  = first ? 8'd1 : sat_inc8(word_cnt);
  assign match_hit = match_en && (idx == MATCH_IDX) &&
                     (((in_data ^ match_value) & match_mask) == '0);
  assign over      = ({1'b0, next_cnt} > MAX_W9);
  assign set_cond  = match_hit || over;
  assign drop_now  = last && (drop_flag || set_cond);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      word_cnt      <= 8'd0;
      drop_flag     <= 1'b0;
      out_fifo_data <= '0;
      fifowrite     <= 1'b0;
      firstword     <= 1'b0;
      lastword      <= 1'b0;
      drop_pkt      <= 1'b0;
    end else begin
      fifowrite <= write;
      firstword <= first;
      lastword  <= last;
      drop_pkt  <= drop_now;
      if (write) begin
        out_fifo_data <= {in_ctrl, in_data};
        word_cnt      <= next_cnt;
        drop_flag     <= first ? set_cond : (drop_flag || set_cond);
      end
      if (accepted) begin
        case (state)
          ST_IDLE:    if (is_hdr) state <= ST_HDR;
          ST_HDR:     if (is_data) state <= ST_PAYLOAD;
                      else if (!is_hdr) state <= ST_IDLE;
          ST_PAYLOAD: if (!is_data) state <= ST_IDLE;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_pkt_cnt (
    .clk (clk),
    .rst (rst),
    .inc (last),
    .cnt (pkt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop_now),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_pkt_classifier.sv
// tb/tb_pkt_classifier.sv - scoreboard bench for pkt_classifier
module tb_pkt_classifier;

  localparam int MAX_W = 200;
  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [63:0]       in_data;
  logic [7:0]        in_ctrl;
  logic              in_wr;
  logic              in_rdy;
  logic              fifo_nearly_full;
  logic              match_en;
  logic [63:0]       match_value;
  logic [63:0]       match_mask;
  logic [71:0]       out_fifo_data;
  logic              fifowrite;
  logic              firstword;
  logic              lastword;
  logic              drop_pkt;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  pkt_classifier #(.MATCH_WORD(2), .MAX_WORDS(MAX_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_data          (in_data),
    .in_ctrl          (in_ctrl),
    .in_wr            (in_wr),
    .in_rdy           (in_rdy),
    .fifo_nearly_full (fifo_nearly_full),
    .match_en         (match_en),
    .match_value      (match_value),
    .match_mask       (match_mask),
    .out_fifo_data    (out_fifo_data),
    .fifowrite        (fifowrite),
    .firstword        (firstword),
    .lastword         (lastword),
    .drop_pkt         (drop_pkt),
    .pkt_cnt          (pkt_cnt),
    .drop_cnt         (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] w;
    logic        f;
    logic        l;
    logic        d;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   bp_en = 0;
  logic [CNT_W-1:0] exp_pkt = '0;
  logic [CNT_W-1:0] exp_drop = '0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fifowrite) begin
      if (q.size() == 0) begin
        check("stray_write", {71'd0, fifowrite}, 72'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("fifo_data", out_fifo_data, e.w);
        check("firstword", {71'd0, firstword}, {71'd0, e.f});
        check("lastword", {71'd0, lastword}, {71'd0, e.l});
        check("drop_pkt", {71'd0, drop_pkt}, {71'd0, e.d});
      end
    end
  end

  task automatic send_word(input logic [7:0] c, input logic [63:0] d, input bit push,
                           input bit f, input bit l, input bit dr);
    int  stalls = 0;
    bit  done = 0;
    bit  nf;
    exp_t e;
    while (!done) begin
      @(negedge clk);
      in_ctrl = c;
      in_data = d;
      in_wr = 1'b1;
      nf = (bp_en && stalls < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      fifo_nearly_full = nf;
      #1;
      check("in_rdy", {71'd0, in_rdy}, {71'd0, !nf});
      @(posedge clk);
      if (!nf) done = 1;
      else stalls++;
    end
    if (push) begin
      e.w = {c, d};
      e.f = f;
      e.l = l;
      e.d = dr;
      q.push_back(e);
    end
  endtask

  task automatic idle_check(input int k);
    @(negedge clk);
    in_wr = 1'b0;
    fifo_nearly_full = 1'b0;
    repeat (k) @(negedge clk);
    #1;
    check("drain", 72'(q.size()), 72'd0);
    check("pkt_cnt", 72'(pkt_cnt), 72'(exp_pkt));
    check("drop_cnt", 72'(drop_cnt), 72'(exp_drop));
  endtask

  task automatic send_pkt(input int nh, input int n, input logic [7:0] lastc,
                          input logic [63:0] w2, input logic [15:0] id);
    bit          exp_d;
    logic [7:0]  c;
    logic [63:0] d;
    exp_d = (n > MAX_W) ||
            (match_en && n >= 3 && (((w2 ^ match_value) & match_mask) == 64'd0));
    for (int i = 0; i < n; i++) begin
      c = (i < nh) ? 8'hFF : ((i == n - 1) ? lastc : 8'h00);
      d = (i == 2) ? w2 : {16'hA5A5, id, 32'(i)};
      send_word(c, d, 1, i == 0, i == n - 1, (i == n - 1) && exp_d);
    end
    if (exp_pkt != '1) exp_pkt++;
    if (exp_d && exp_drop != '1) exp_drop++;
    idle_check(3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fifowrite"}, {71'd0, fifowrite}, 72'd0);
    check({tag, "_first"}, {71'd0, firstword}, 72'd0);
    check({tag, "_last"}, {71'd0, lastword}, 72'd0);
    check({tag, "_drop"}, {71'd0, drop_pkt}, 72'd0);
    check({tag, "_data"}, out_fifo_data, 72'd0);
    check({tag, "_pkt_cnt"}, 72'(pkt_cnt), 72'd0);
    check({tag, "_drop_cnt"}, 72'(drop_cnt), 72'd0);
    check({tag, "_in_rdy"}, {71'd0, in_rdy}, 72'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_ctrl = '0;
    in_wr = 1'b0;
    fifo_nearly_full = 1'b0;
    match_en = 1'b0;
    match_value = '0;
    match_mask = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // basic framing, single-header and multi-header shapes
    send_pkt(1, 5, 8'h0F, 64'h1111_2222_3333_4444, 16'd1);
    send_pkt(1, 2, 8'h03, 64'h0, 16'd2);
    send_pkt(2, 4, 8'hFF, 64'h5555_6666_7777_8888, 16'd3);

    // masked field match on word 2
    match_en = 1'b1;
    match_mask = 64'hFFFF_0000_0000_0000;
    match_value = 64'h0800_0000_0000_0000;
    send_pkt(1, 5, 8'h0F, 64'h0800_1234_5678_9ABC, 16'd4);
    send_pkt(1, 5, 8'h0F, 64'h0900_1234_5678_9ABC, 16'd5);
    send_pkt(1, 2, 8'h01, 64'h0, 16'd6);
    match_en = 1'b0;
    send_pkt(1, 5, 8'h0F, 64'h0800_1234_5678_9ABC, 16'd7);

    // oversize boundary
    send_pkt(1, MAX_W + 1, 8'hFF, 64'h0, 16'd8);
    send_pkt(1, MAX_W, 8'hFF, 64'h0, 16'd9);

    // backpressure with random stalls
    bp_en = 1;
    send_pkt(1, 12, 8'h7F, 64'hDEAD_BEEF_0000_0001, 16'd10);
    send_pkt(3, 6, 8'h01, 64'hDEAD_BEEF_0000_0002, 16'd11);
    bp_en = 0;

    // stray words in IDLE leave everything untouched
    for (int i = 0; i < 3; i++) send_word(8'h00, 64'(i), 0, 0, 0, 0);
    send_word(8'h3C, 64'h77, 0, 0, 0, 0);
    idle_check(3);

    // reset mid-payload abandons the packet
    send_word(8'hFF, 64'hAAAA, 1, 1, 0, 0);
    send_word(8'h00, 64'hBBBB, 1, 0, 0, 0);
    send_word(8'h00, 64'hCCCC, 1, 0, 0, 0);
    @(negedge clk);
    in_wr = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_in_rdy_comb", {71'd0, in_rdy}, 72'd0);
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    exp_pkt = '0;
    exp_drop = '0;
    send_pkt(1, 4, 8'h0F, 64'h0, 16'd12);

    // pkt_cnt saturation
    @(negedge clk);
    force dut.u_pkt_cnt.cnt = {CNT_W{1'b1}};
    @(negedge clk);
    release dut.u_pkt_cnt.cnt;
    exp_pkt = '1;
    send_pkt(1, 3, 8'h0F, 64'h0, 16'd13);
    check("pkt_cnt_sat", 72'(pkt_cnt), {40'd0, 32'hFFFF_FFFF});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
